rd_stream_ctrl: RTL and testbench
=================================

RD_STREAM_CTRL -- requirements
Module: rd_stream_ctrl

Interface
REQ-001 SHALL have parameter DataWidth, default 32, stream data width.
REQ-002 SHALL have parameter AddrWidth, default 32, memory address width.
REQ-003 SHALL have parameter LenWidth, default 16, width of length and loop counts.
REQ-004 SHALL use a single clock and a synchronous, active-high reset: `clk_i  input  1  clock`, all state sampled on the rising edge.
REQ-005 `rst_i  input  1`: synchronous active-high reset.
REQ-006 `start_i  input  1`: start pulse; config is latched on the start cycle.
REQ-007 `stop_i  input  1`: abort request.
REQ-008 `cfg_base_addr_i  input  AddrWidth`: first word address.
REQ-009 `cfg_len_i  input  LenWidth`: words per pass.
REQ-010 `cfg_loops_i  input  LenWidth`: number of passes.
REQ-011 `mem_addr_o  output  AddrWidth`: read address to the memory; read is combinational.
REQ-012 `mem_data_i  input  DataWidth`: memory data for mem_addr_o, same cycle.
REQ-013 `data_o  output  DataWidth`: stream data.
REQ-014 `valid_o  output  1`: stream valid.
REQ-015 `ready_i  input  1`: stream ready.
REQ-016 `last_o  output  1`: final word of final pass.
REQ-017 `busy_o  output  1`: state != IDLE.
REQ-018 `done_o  output  1`: one-cycle completion pulse.
REQ-019 `pass_cnt_o  output  LenWidth`: passes fully issued.

Function
REQ-020 SHALL implement the states IDLE, RUN, DRAIN and DONE; all outputs except mem_addr_o and data_o SHALL be registered.
REQ-021 In IDLE, start_i SHALL latch base/len/loops, clear word_idx, pass_idx and pass_cnt_o, and go to RUN; if len==0 or loops==0 it SHALL go to DONE instead.
REQ-022 mem_addr_o SHALL equal base_q + word_idx, computed modulo 2^AddrWidth, at all times.
REQ-023 The load condition SHALL be: state==RUN and (!valid_o or ready_i).
REQ-024 On a load, the block SHALL capture data_o<=mem_data_i and set valid_o<=1, with last_o<=(word_idx==len-1 and pass_idx==loops-1).
REQ-025 On a load, word_idx SHALL increment; at len-1 it SHALL wrap to 0, and pass_idx and pass_cnt_o SHALL increment.
REQ-026 On the final load, the next state SHALL be DRAIN.
REQ-027 A beat SHALL be accepted when valid_o and ready_i are both high; an accepted beat with no same-cycle load SHALL clear valid_o.
REQ-028 While valid_o is high and ready_i is low, data_o, last_o, valid_o and mem_addr_o SHALL hold stable.
REQ-029 Full throughput SHALL be one beat per cycle while ready_i is high.
REQ-030 In DRAIN, acceptance SHALL clear valid_o and last_o and move to DONE.
REQ-031 DONE SHALL assert done_o for exactly one cycle and then go to IDLE.
REQ-032 stop_i in RUN or DRAIN SHALL clear valid_o and last_o on the next edge, discarding the held word, and SHALL go to DONE; done_o SHALL still pulse.
REQ-033 stop_i in IDLE or DONE SHALL be ignored.
REQ-034 start_i SHALL be ignored when not in IDLE; if start_i and stop_i are both high in IDLE, start SHALL win.
REQ-035 Config input changes after the start cycle SHALL have no effect.
REQ-036 Latency: with start_i high in cycle t, valid_o SHALL first be high in cycle t+2.

Reset
REQ-037 rst_i SHALL force IDLE and clear word_idx, pass_idx, base_q, len_q and loops_q to 0.
REQ-038 rst_i SHALL drive valid_o=0, last_o=0, done_o=0, busy_o=0, pass_cnt_o=0, data_o=0 and mem_addr_o=0.
REQ-039 Reset mid-stream SHALL take effect on the next edge, with no done_o pulse.

Verification
REQ-040 base=0x10, len=4, loops=1, ready=1, start at t -> beats mem[0x10..0x13] in t+2..t+5, last_o at t+5, done_o at t+6, busy_o=0 at t+7.
REQ-041 Same config, ready=0 for 3 cycles after the 2nd beat is presented -> data_o, valid_o and mem_addr_o frozen; 4 beats total in order; no duplicates or drops.
REQ-042 base=0x20, len=3, loops=2 -> beats 0x20,0x21,0x22,0x20,0x21,0x22; last_o only on the 6th; pass_cnt_o reads 1 then 2.
REQ-043 stop_i on the 2nd beat cycle -> valid_o=0 next cycle, done_o pulse, busy_o clears; a new start then streams correctly from its base.
REQ-044 len=0 or loops=0, start at t -> valid_o never high, done_o at t+1.
REQ-045 base=0xFFFFFFFE, len=4 -> mem_addr_o sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.

Source files
------------

// File: rtl/rd_stream_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | rd_stream_ctrl_if : control, memory-read and stream signals of the reader   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface rd_stream_ctrl_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32,
  parameter int LenWidth  = 16
) ();

  logic                 start_i;
  logic                 stop_i;
  logic [AddrWidth-1:0] cfg_base_addr_i;
  logic [LenWidth-1:0]  cfg_len_i;
  logic [LenWidth-1:0]  cfg_loops_i;
  logic [AddrWidth-1:0] mem_addr_o;
  logic [DataWidth-1:0] mem_data_i;
  logic [DataWidth-1:0] data_o;
  logic                 valid_o;
  logic                 ready_i;
  logic                 last_o;
  logic                 busy_o;
  logic                 done_o;
  logic [LenWidth-1:0]  pass_cnt_o;

  // The controller side.
  modport master (
    input  start_i, stop_i, cfg_base_addr_i, cfg_len_i, cfg_loops_i,
    input  mem_data_i, ready_i,
    output mem_addr_o, data_o, valid_o, last_o, busy_o, done_o, pass_cnt_o
  );

  // The environment side: memory, stream sink and configuring host.
  modport slave (
    output start_i, stop_i, cfg_base_addr_i, cfg_len_i, cfg_loops_i,
    output mem_data_i, ready_i,
    input  mem_addr_o, data_o, valid_o, last_o, busy_o, done_o, pass_cnt_o
  );

endinterface

`default_nettype wire

// File: rtl/rd_stream_ctrl.sv
// +----------------------------------------------------------------------------+
// | rd_stream_ctrl : reads len words from base, loops times, onto a           |
// | valid/ready stream with a one-word output register.  Revision: 1.0         |
// +----------------------------------------------------------------------------+
`default_nettype none

module rd_stream_ctrl #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32,
  parameter int LenWidth  = 16
) (
  input  wire logic         clk_i,
  input  wire logic         rst_i,
  rd_stream_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] base_q, base_d;
  logic [LenWidth-1:0]  len_q, len_d;
  logic [LenWidth-1:0]  loops_q, loops_d;
  logic [LenWidth-1:0]  word_idx_q, word_idx_d;
  logic [LenWidth-1:0]  pass_idx_q, pass_idx_d;
  logic [LenWidth-1:0]  pass_cnt_q, pass_cnt_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic load;
  logic accept;
  logic word_end;
  logic pass_end;
  logic final_word;

  // The output register refills whenever it is empty or being drained this cycle.
  assign load       = (state_q == ST_RUN) && (!valid_q || bus.ready_i);
  assign accept     = valid_q && bus.ready_i;
  assign word_end   = (word_idx_q == (len_q - LenWidth'(1)));
  assign pass_end   = (pass_idx_q == (loops_q - LenWidth'(1)));
  assign final_word = word_end && pass_end;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    loops_d    = loops_q;
    word_idx_d = word_idx_q;
    pass_idx_d = pass_idx_q;
    pass_cnt_d = pass_cnt_q;
    data_d     = data_q;
    valid_d    = valid_q;
    last_d     = last_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          base_d     = bus.cfg_base_addr_i;
          len_d      = bus.cfg_len_i;
          loops_d    = bus.cfg_loops_i;
          word_idx_d = '0;
          pass_idx_d = '0;
          pass_cnt_d = '0;
          if ((bus.cfg_len_i == '0) || (bus.cfg_loops_i == '0)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (bus.stop_i) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = ST_DONE;
        end else if (load) begin
          data_d  = bus.mem_data_i;
          valid_d = 1'b1;
          last_d  = final_word;
          if (word_end) begin
            word_idx_d = '0;
            pass_idx_d = pass_idx_q + LenWidth'(1);
            pass_cnt_d = pass_cnt_q + LenWidth'(1);
          end else begin
            word_idx_d = word_idx_q + LenWidth'(1);
          end
          if (final_word) begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (bus.stop_i || accept) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are registered copies of the state being entered.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      loops_q    <= '0;
      word_idx_q <= '0;
      pass_idx_q <= '0;
      pass_cnt_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      loops_q    <= loops_d;
      word_idx_q <= word_idx_d;
      pass_idx_q <= pass_idx_d;
      pass_cnt_q <= pass_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.mem_addr_o = base_q + AddrWidth'(word_idx_q);
  assign bus.data_o     = data_q;
  assign bus.valid_o    = valid_q;
  assign bus.last_o     = last_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.pass_cnt_o = pass_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_rd_stream_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_rd_stream_ctrl : bench for rd_stream_ctrl with a queue-based reference. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rd_stream_ctrl;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int LW = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rd_stream_ctrl_if #(.DataWidth(DW), .AddrWidth(AW), .LenWidth(LW)) bus ();

  rd_stream_ctrl #(.DataWidth(DW), .AddrWidth(AW), .LenWidth(LW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign bus.mem_data_i = memf(bus.mem_addr_o);

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a started job becomes a queue of words still to be read.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic          pass_end;
  } beat_t;

  beat_t         q[$];
  beat_t         b;
  int            m_phase;   // 0 idle, 1 streaming, 2 completion pulse
  logic          m_valid;
  logic          m_last;
  logic [AW-1:0] m_base;
  logic [DW-1:0] m_data;
  logic [LW-1:0] m_pcnt;
  bit            chk_en = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_phase = 0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_base  = '0;
        m_data  = '0;
        m_pcnt  = '0;
        q.delete();
        chk_en  = 1'b1;
      end else begin
        case (m_phase)
          0: begin
            if (bus.start_i) begin
              m_base = bus.cfg_base_addr_i;
              m_pcnt = '0;
              q.delete();
              if (bus.cfg_len_i == 0 || bus.cfg_loops_i == 0) begin
                m_phase = 2;
              end else begin
                for (int p = 0; p < int'(bus.cfg_loops_i); p++) begin
                  for (int w = 0; w < int'(bus.cfg_len_i); w++) begin
                    b.addr     = m_base + AW'(w);
                    b.pass_end = (w == int'(bus.cfg_len_i) - 1);
                    q.push_back(b);
                  end
                end
                m_phase = 1;
              end
            end
          end
          1: begin
            if (bus.stop_i) begin
              m_valid = 1'b0;
              m_last  = 1'b0;
              m_phase = 2;
            end else if (!m_valid || bus.ready_i) begin
              if (q.size() > 0) begin
                b       = q.pop_front();
                m_data  = memf(b.addr);
                m_valid = 1'b1;
                m_last  = (q.size() == 0);
                if (b.pass_end) m_pcnt = m_pcnt + 1'b1;
              end else begin
                m_valid = 1'b0;
                m_last  = 1'b0;
                m_phase = 2;
              end
            end
          end
          default: m_phase = 0;
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("busy",     bus.busy_o,     m_phase != 0);
        check("done",     bus.done_o,     m_phase == 2);
        check("valid",    bus.valid_o,    m_valid);
        check("last",     bus.last_o,     m_last);
        check("pass_cnt", bus.pass_cnt_o, m_pcnt);
        check("data",     bus.data_o,     m_data);
        check("mem_addr", bus.mem_addr_o, (q.size() > 0) ? q[0].addr : m_base);
      end
    end
  end

  task automatic start_cfg(input logic [AW-1:0] base, input logic [LW-1:0] len,
                           input logic [LW-1:0] loops);
    @(negedge clk);
    bus.start_i         = 1'b1;
    bus.cfg_base_addr_i = base;
    bus.cfg_len_i       = len;
    bus.cfg_loops_i     = loops;
  endtask

  // Later config changes must not matter, so scramble them every cycle.
  task automatic step();
    @(negedge clk);
    bus.start_i         = 1'b0;
    bus.cfg_base_addr_i = $urandom;
    bus.cfg_len_i       = LW'($urandom);
    bus.cfg_loops_i     = LW'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && bus.busy_o; i++) step();
    check("wait_idle", bus.busy_o, 1'b0);
    step();
  endtask

  logic [AW-1:0] exp45 [4];

  initial begin
    rst                 = 1'b1;
    bus.start_i         = 1'b0;
    bus.stop_i          = 1'b0;
    bus.ready_i         = 1'b1;
    bus.cfg_base_addr_i = '0;
    bus.cfg_len_i       = '0;
    bus.cfg_loops_i     = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", bus.valid_o, 1'b0);
    check("rst_busy",  bus.busy_o,  1'b0);
    check("rst_addr",  bus.mem_addr_o, 32'h0);
    check("rst_data",  bus.data_o,  32'h0);
    rst = 1'b0;

    // Basic four-word pass.
    start_cfg(32'h10, 16'd4, 16'd1);
    for (int k = 1; k <= 7; k++) begin
      step();
      check("t040_valid", bus.valid_o, (k >= 2 && k <= 5));
      if (k >= 2 && k <= 5) check("t040_data", bus.data_o, 32'hC0DE0010 + 32'(k - 2));
      check("t040_last", bus.last_o, k == 5);
      check("t040_done", bus.done_o, k == 6);
      check("t040_busy", bus.busy_o, k <= 6);
    end
    wait_idle();

    // Back-pressure after the second beat.
    start_cfg(32'h10, 16'd4, 16'd1);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 3) bus.ready_i = 1'b0;
      if (k >= 4) begin
        check("t041_data",  bus.data_o,     32'hC0DE0011);
        check("t041_valid", bus.valid_o,    1'b1);
        check("t041_addr",  bus.mem_addr_o, 32'h12);
      end
    end
    bus.ready_i = 1'b1;
    wait_idle();

    // Two passes of three.
    start_cfg(32'h20, 16'd3, 16'd2);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("t042_valid", bus.valid_o, (k >= 2 && k <= 7));
      if (k >= 2 && k <= 7) check("t042_data", bus.data_o, 32'hC0DE0020 + 32'((k - 2) % 3));
      check("t042_last", bus.last_o, k == 7);
      check("t042_pcnt", bus.pass_cnt_o, (k <= 3) ? 16'd0 : (k <= 6) ? 16'd1 : 16'd2);
      check("t042_done", bus.done_o, k == 8);
    end
    wait_idle();

    // Abort on the second beat, then restart.
    start_cfg(32'h40, 16'd8, 16'd1);
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 3) bus.stop_i = 1'b1;
      if (k == 4) begin
        bus.stop_i = 1'b0;
        check("t043_valid", bus.valid_o, 1'b0);
        check("t043_done",  bus.done_o,  1'b1);
      end
      if (k == 5) check("t043_busy", bus.busy_o, 1'b0);
    end
    start_cfg(32'h50, 16'd2, 16'd1);
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k >= 2) check("t043_rdata", bus.data_o, 32'hC0DE0050 + 32'(k - 2));
      if (k == 3) check("t043_rlast", bus.last_o, 1'b1);
    end
    wait_idle();

    // Empty jobs complete immediately.
    start_cfg(32'h30, 16'd0, 16'd5);
    step();
    check("t044a_done",  bus.done_o,  1'b1);
    check("t044a_valid", bus.valid_o, 1'b0);
    step();
    check("t044a_busy",  bus.busy_o,  1'b0);
    start_cfg(32'h30, 16'd3, 16'd0);
    step();
    check("t044b_done",  bus.done_o,  1'b1);
    check("t044b_valid", bus.valid_o, 1'b0);
    wait_idle();

    // Address wrap.
    exp45[0] = 32'hFFFFFFFE;
    exp45[1] = 32'hFFFFFFFF;
    exp45[2] = 32'h00000000;
    exp45[3] = 32'h00000001;
    start_cfg(32'hFFFFFFFE, 16'd4, 16'd1);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("t045_addr", bus.mem_addr_o, exp45[k-1]);
    end
    wait_idle();

    // Reset mid-stream: no completion pulse.
    start_cfg(32'h60, 16'd4, 16'd1);
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 3) rst = 1'b1;
      if (k == 4) begin
        rst = 1'b0;
        check("t039_valid", bus.valid_o,    1'b0);
        check("t039_busy",  bus.busy_o,     1'b0);
        check("t039_done",  bus.done_o,     1'b0);
        check("t039_addr",  bus.mem_addr_o, 32'h0);
      end
      if (k == 5) check("t039_done2", bus.done_o, 1'b0);
    end

    // Randomized traffic against the reference.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst         = ($urandom_range(0, 299) == 0);
      bus.start_i = ($urandom_range(0, 7) == 0);
      bus.stop_i  = ($urandom_range(0, 59) == 0);
      bus.ready_i = ($urandom_range(0, 9) < 7);
      bus.cfg_base_addr_i = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3)))
                                                         : 32'($urandom);
      bus.cfg_len_i   = LW'($urandom_range(0, 5));
      bus.cfg_loops_i = LW'($urandom_range(0, 3));
    end
    @(negedge clk);
    rst         = 1'b0;
    bus.start_i = 1'b0;
    bus.stop_i  = 1'b0;
    bus.ready_i = 1'b1;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
